// File: rtl/sdram_pkg.sv
// Shared SDRAM refresh types, default timing constants and width helpers.
// Used by refresh_scheduler and ref_interval_counter.
package sdram_pkg;

  typedef enum logic {
    MODE_DISTRIB = 1'b0,
    MODE_BURST   = 1'b1
  } ref_mode_e;

  // 64 ms refresh period at 60 MHz, 8192 rows
  localparam int unsigned DEF_PERIOD_CYCLES = 3840000;
  localparam int unsigned DEF_REFRESHES     = 8192;
  localparam int unsigned DEF_TRFC_CYCLES   = 5;
  localparam int unsigned DEF_MAX_DEBT      = 8;
  localparam int unsigned DEF_GUARD         = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = 32'(i) + 32'd1;
    end
    return result;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/ref_interval_counter.sv
// Wrap counter 0..LIMIT-1 with enable and synchronous clear.
// tick is high in the enabled cycle whose clock edge wraps the counter.
module ref_interval_counter
  import sdram_pkg::*;
#(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned W     = cnt_w(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tick
);

  assign tick = en && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// SDRAM refresh scheduler: period tracking, refresh debt, request/urgent generation.
// Optional REF_SCHED_STATS_EN adds a saturating miss_cnt[15:0] output.
module refresh_scheduler
  import sdram_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned REFRESHES     = DEF_REFRESHES,
  parameter int unsigned TRFC_CYCLES   = DEF_TRFC_CYCLES,
  parameter int unsigned MAX_DEBT      = DEF_MAX_DEBT,
  parameter int unsigned GUARD         = DEF_GUARD
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            mode,
  input  logic                            ref_ack,
  output logic                            ref_req,
  output logic                            ref_urgent,
  output logic                            period_start,
  output logic [clog2(REFRESHES + 1)-1:0] done_cnt,
  output logic                            underrun
`ifdef REF_SCHED_STATS_EN
  ,
  output logic [15:0]                     miss_cnt
`endif
);

  localparam int unsigned INTERVAL   = PERIOD_CYCLES / REFRESHES;
  localparam int unsigned FORCE_TIME = PERIOD_CYCLES - REFRESHES * TRFC_CYCLES - GUARD;
  localparam int unsigned PER_W      = cnt_w(PERIOD_CYCLES);
  localparam int unsigned INT_W      = cnt_w(INTERVAL);
  localparam int unsigned DONE_W     = clog2(REFRESHES + 1);
  localparam int unsigned DEBT_W     = cnt_w(MAX_DEBT + 1);

  logic [PER_W-1:0]  period_cnt;
  logic [PER_W-1:0]  period_cnt_d;
  logic [INT_W-1:0]  int_cnt;
  logic              period_wrap;
  logic              int_tick;
  ref_mode_e         mode_q;
  ref_mode_e         mode_d;
  logic [DEBT_W-1:0] debt;
  logic [DEBT_W-1:0] debt_d;
  logic [DONE_W-1:0] done_inc;
  logic [DONE_W-1:0] done_d;
  logic              ack_ok;
  logic              tick_due;
  logic              debt_full;
  logic              pending_d;
  logic              force_d;
  logic              req_d;
  logic              urgent_d;
  logic              underrun_d;
  logic              unused_int_cnt;

  ref_interval_counter #(
    .LIMIT (PERIOD_CYCLES),
    .W     (PER_W)
  ) u_period_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (1'b0),
    .cnt  (period_cnt),
    .tick (period_wrap)
  );

  // Restarted at every period wrap so ticks stay aligned to the period.
  ref_interval_counter #(
    .LIMIT (INTERVAL),
    .W     (INT_W)
  ) u_int_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (period_wrap),
    .cnt  (int_cnt),
    .tick (int_tick)
  );

  // Interval position is only consumed through its tick.
  assign unused_int_cnt = ^int_cnt;

  // Next-state of every register; outputs are registered from these values
  // so they describe the state that exists after the current edge.
  always_comb begin
    ack_ok    = en && ref_ack && ref_req;
    debt_full = (debt == DEBT_W'(MAX_DEBT));
    tick_due  = (mode_q == MODE_DISTRIB) && int_tick
                && ((32'(done_cnt) + 32'(debt)) < REFRESHES);

    done_inc = done_cnt;
    if (ack_ok && (done_cnt != DONE_W'(REFRESHES))) begin
      done_inc = done_cnt + DONE_W'(1);
    end

    debt_d = debt;
    if (tick_due && !ack_ok && !debt_full) begin
      debt_d = debt + DEBT_W'(1);
    end else if (ack_ok && !tick_due && (debt != '0)) begin
      debt_d = debt - DEBT_W'(1);
    end

    // A same-cycle ack is credited to the ending period before the clear.
    underrun_d = period_wrap && (32'(done_inc) < REFRESHES);

    done_d       = done_inc;
    mode_d       = mode_q;
    period_cnt_d = period_cnt;
    if (period_wrap) begin
      done_d       = '0;
      debt_d       = '0;
      mode_d       = ref_mode_e'(mode);
      period_cnt_d = '0;
    end else if (en) begin
      period_cnt_d = period_cnt + PER_W'(1);
    end

    pending_d = (32'(done_d) < REFRESHES);
    force_d   = en && pending_d && (32'(period_cnt_d) >= FORCE_TIME);

    if (mode_d == MODE_BURST) begin
      req_d    = force_d;
      urgent_d = force_d;
    end else begin
      req_d    = en && ((debt_d != '0) || force_d);
      urgent_d = en && ((debt_d == DEBT_W'(MAX_DEBT)) || force_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_DISTRIB;
      debt         <= '0;
      done_cnt     <= '0;
      ref_req      <= 1'b0;
      ref_urgent   <= 1'b0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      debt         <= debt_d;
      done_cnt     <= done_d;
      ref_req      <= req_d;
      ref_urgent   <= urgent_d;
      period_start <= period_wrap;
      underrun     <= underrun_d;
    end
  end

`ifdef REF_SCHED_STATS_EN
  logic        tick_miss;
  logic [16:0] miss_sum;

  // Underrun and a dropped wrap-cycle tick can both land on one edge.
  always_comb begin
    tick_miss = tick_due && debt_full && !ack_ok;
    miss_sum  = 17'(miss_cnt) + 17'(tick_miss) + 17'(underrun_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= '0;
    end else begin
      miss_cnt <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler: period/interval timing, debt, burst, freeze, reset.
// Expected underrun per period is queued at stimulus time and checked at each period_start.
module tb_refresh_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       ref_ack;
  logic       ref_req;
  logic       ref_urgent;
  logic       period_start;
  logic [3:0] done_cnt;
  logic       underrun;
`ifdef REF_SCHED_STATS_EN
  logic [15:0] miss_cnt;
`endif

  logic       auto_ack;
  logic       auto_pulse;
  logic       man_ack;
  int         n_assert;
  int         n_fail;
  int         t;
  logic [0:0] exp_q[$];

  assign ref_ack = auto_pulse | man_ack;

  refresh_scheduler #(
    .PERIOD_CYCLES (200),
    .REFRESHES     (8),
    .TRFC_CYCLES   (5),
    .MAX_DEBT      (4),
    .GUARD         (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .ref_ack      (ref_ack),
    .ref_req      (ref_req),
    .ref_urgent   (ref_urgent),
    .period_start (period_start),
    .done_cnt     (done_cnt),
    .underrun     (underrun)
`ifdef REF_SCHED_STATS_EN
    ,
    .miss_cnt     (miss_cnt)
`endif
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish within 100 us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // t counts rising edges since the last reset release; called at negedges.
  task automatic adv_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Responder: acknowledges two cycles after it sees ref_req high.
  initial begin
    auto_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && ref_req === 1'b1) begin
        @(negedge clk);
        @(negedge clk);
        auto_pulse = 1'b1;
        @(negedge clk);
        auto_pulse = 1'b0;
      end
    end
  end

  // Scoreboard: each period_start pops the expected underrun of the period that ended.
  always @(negedge clk) begin
    if (rst === 1'b0 && underrun === 1'b1) check("underrun_align", 32'(period_start), 32'd1);
    if (rst === 1'b0 && period_start === 1'b1) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("sb_underrun", 32'(underrun), 32'(exp_q.pop_front()));
        check("sb_done_clear", 32'(done_cnt), 32'd0);
      end
    end
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    t        = 0;
    rst      = 1'b1;
    en       = 1'b1;
    mode     = 1'b0;
    man_ack  = 1'b0;
    auto_ack = 1'b0;

    // 1: reset with en=1
    repeat (3) @(negedge clk);
    check("rst_req", 32'(ref_req), 32'd0);
    check("rst_urgent", 32'(ref_urgent), 32'd0);
    check("rst_start", 32'(period_start), 32'd0);
    check("rst_done", 32'(done_cnt), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    t = 0;

    // 2: distributed with acks; all 8 refreshes land before the wrap
    auto_ack = 1'b1;
    exp_q.push_back(1'b0);
    adv_to(24);
    check("p1_req_before_tick", 32'(ref_req), 32'd0);
    adv_to(25);
    check("p1_req_first", 32'(ref_req), 32'd1);
    adv_to(180);
    auto_ack = 1'b0;
    adv_to(199);
    check("p1_done_full", 32'(done_cnt), 32'd8);
    check("p1_start_early", 32'(period_start), 32'd0);
    exp_q.push_back(1'b1);
    adv_to(200);
    check("p1_start", 32'(period_start), 32'd1);

    // 3: distributed, no acks; debt saturates, force window, underrun
    adv_to(299);
    check("p2_urgent_debt3", 32'(ref_urgent), 32'd0);
    adv_to(300);
    check("p2_urgent_debt4", 32'(ref_urgent), 32'd1);
    check("p2_req_debt4", 32'(ref_req), 32'd1);
    adv_to(310);
    mode = 1'b1;
    adv_to(320);
    check("p2_mode_flip_held", 32'(ref_req), 32'd1);
    adv_to(360);
    check("p2_force_req", 32'(ref_req), 32'd1);
    check("p2_force_urgent", 32'(ref_urgent), 32'd1);
    exp_q.push_back(1'b0);
    adv_to(400);
    check("p2_start", 32'(period_start), 32'd1);
`ifdef REF_SCHED_STATS_EN
    check("p2_miss_cnt", 32'(miss_cnt), 32'd5);
`endif

    // 4: burst; request at period_cnt 156, drops after the 8th ack
    adv_to(555);
    check("p3_req_pre_force", 32'(ref_req), 32'd0);
    adv_to(556);
    check("p3_req_force", 32'(ref_req), 32'd1);
    check("p3_urgent_force", 32'(ref_urgent), 32'd1);
    adv_to(558);
    man_ack = 1'b1;
    adv_to(565);
    check("p3_done7", 32'(done_cnt), 32'd7);
    check("p3_req_at7", 32'(ref_req), 32'd1);
    adv_to(566);
    man_ack = 1'b0;
    check("p3_done8", 32'(done_cnt), 32'd8);
    check("p3_req_drop", 32'(ref_req), 32'd0);
    check("p3_urgent_drop", 32'(ref_urgent), 32'd0);
    adv_to(570);
    mode = 1'b0;
    exp_q.push_back(1'b1);

    // 6a: ack while ref_req=0 is ignored
    adv_to(609);
    man_ack = 1'b1;
    adv_to(610);
    man_ack = 1'b0;
    adv_to(611);
    check("p4_ack_no_req", 32'(done_cnt), 32'd0);

    // 5: freeze for 50 cycles at period_cnt 60
    adv_to(660);
    check("p4_req_debt2", 32'(ref_req), 32'd1);
    en = 1'b0;
    adv_to(670);
    check("p4_frozen_req", 32'(ref_req), 32'd0);
    adv_to(679);
    man_ack = 1'b1;
    adv_to(680);
    man_ack = 1'b0;
    adv_to(685);
    check("p4_frozen_ack", 32'(done_cnt), 32'd0);
    adv_to(710);
    check("p4_frozen_end", 32'(ref_req), 32'd0);
    en = 1'b1;
    adv_to(711);
    check("p4_resume_req", 32'(ref_req), 32'd1);

    // 6b: tick and ack on the same edge leave debt at 3
    adv_to(749);
    man_ack = 1'b1;
    adv_to(750);
    man_ack = 1'b0;
    adv_to(751);
    check("p4_tick_ack_done", 32'(done_cnt), 32'd1);
    adv_to(774);
    check("p4_debt3_urgent", 32'(ref_urgent), 32'd0);
    adv_to(775);
    check("p4_debt4_urgent", 32'(ref_urgent), 32'd1);
    adv_to(849);
    check("p4_start_early", 32'(period_start), 32'd0);
    exp_q.push_back(1'b1);
    adv_to(850);
    check("p4_start_250", 32'(period_start), 32'd1);
`ifdef REF_SCHED_STATS_EN
    check("p4_miss_cnt", 32'(miss_cnt), 32'd9);
`endif

    // reset mid-period: outputs clear, no underrun, timing restarts
    adv_to(880);
    check("p5_req_before_rst", 32'(ref_req), 32'd1);
    rst = 1'b1;
    adv_to(882);
    check("mid_rst_req", 32'(ref_req), 32'd0);
    check("mid_rst_urgent", 32'(ref_urgent), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    check("mid_rst_start", 32'(period_start), 32'd0);
`ifdef REF_SCHED_STATS_EN
    check("mid_rst_miss", 32'(miss_cnt), 32'd0);
`endif
    rst = 1'b0;
    t = 0;
    adv_to(199);
    check("r_start_early", 32'(period_start), 32'd0);
    adv_to(200);
    check("r_start", 32'(period_start), 32'd1);
    adv_to(205);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
